pulse_width_meter: RTL

PULSE_WIDTH_METER -- requirements
Module: pulse_width_meter

---
 rtl/pulse_width_meter.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/pulse_width_meter.sv
// -----------------------------------------------------------------------------
// pulse_width_meter
//
// Measures the high time and the period of a signal. The signal arrives as
// single-cycle rising/falling edge pulses from an upstream edge detector.
// A running counter starts at a rising edge. A falling edge latches the high
// time. The next rising edge closes the period and starts the following
// measurement back-to-back. Each result is offered on a valid/ready
// handshake. A result that completes while an earlier one is still held is
// dropped, and the sticky overrun flag is raised.
//
// Ports
//   driver_clk  in   system clock, rising edge
//   resetn      in   asynchronous reset, active HIGH (the existing reset net)
//   pos_edge    in   rising-edge pulse
//   neg_edge    in   falling-edge pulse
//   meas_ready  in   consumer accepts the held result
//   meas_valid  out  a result is held
//   high_cnt    out  high time in clocks      (CNT_W bits)
//   period_cnt  out  period in clocks         (CNT_W bits)
//   meas_sat    out  held result saturated
//   overrun     out  sticky: a result was dropped
//   err         out  one-cycle protocol-error pulse
// -----------------------------------------------------------------------------
module pulse_width_meter #(
  parameter int CNT_W = 16
) (
  input  logic             driver_clk,
  input  logic             resetn,
  input  logic             pos_edge,
  input  logic             neg_edge,
  input  logic             meas_ready,
  output logic             meas_valid,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] period_cnt,
  output logic             meas_sat,
  output logic             overrun,
  output logic             err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e           state_q;
  logic [CNT_W-1:0] r_q;
  logic [CNT_W-1:0] high_lat_q;
  logic             sat_q;
  logic             meas_valid_q;
  logic [CNT_W-1:0] high_cnt_q;
  logic [CNT_W-1:0] period_cnt_q;
  logic             meas_sat_q;
  logic             overrun_q;
  logic             err_q;

  logic [CNT_W-1:0] r_d;
  logic             sat_d;
  logic             both_edges;
  logic             complete;
  logic             load;

  // Saturating increment of the running counter. Hitting the ceiling with
  // another clock still to count means the true value no longer fits.
  // NOTE: every always_comb output gets a default first so that no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    r_d   = r_q;
    sat_d = sat_q;
    if (r_q == CNT_MAX) begin
      sat_d = 1'b1;
    end else begin
      r_d = r_q + CNT_ONE;
    end
  end

  assign both_edges = pos_edge & neg_edge;
  // A clean rising edge in LOW closes the period.
  assign complete   = (state_q == LOW) && pos_edge && !neg_edge;
  // A new result may load if the slot is empty or is being emptied this cycle.
  assign load       = complete && (!meas_valid_q || meas_ready);

  // NOTE: sequential state uses non-blocking assignments only. Every register
  // then samples the pre-edge values, whatever order the statements are in.
  always_ff @(posedge driver_clk or posedge resetn) begin
    if (resetn) begin
      state_q      <= IDLE;
      r_q          <= '0;
      high_lat_q   <= '0;
      sat_q        <= 1'b0;
      meas_valid_q <= 1'b0;
      high_cnt_q   <= '0;
      period_cnt_q <= '0;
      meas_sat_q   <= 1'b0;
      overrun_q    <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      err_q <= 1'b0;

      // Measurement FSM. Both edges at once are impossible from a real
      // signal, so the FSM abandons whatever it was tracking.
      if (both_edges) begin
        err_q   <= 1'b1;
        r_q     <= '0;
        state_q <= IDLE;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (pos_edge) begin
              r_q     <= CNT_ONE;
              sat_q   <= 1'b0;
              state_q <= HIGH;
            end
          end
          HIGH: begin
            if (pos_edge) begin
              // The fall was missed. Restart the measurement from this rise.
              err_q <= 1'b1;
              r_q   <= CNT_ONE;
              sat_q <= 1'b0;
            end else begin
              r_q   <= r_d;
              sat_q <= sat_d;
              if (neg_edge) begin
                high_lat_q <= r_q;
                state_q    <= LOW;
              end
            end
          end
          LOW: begin
            if (pos_edge) begin
              r_q     <= CNT_ONE;
              sat_q   <= 1'b0;
              state_q <= HIGH;
            end else if (neg_edge) begin
              // The rise was missed. Wait for a fresh rise.
              err_q   <= 1'b1;
              r_q     <= '0;
              sat_q   <= 1'b0;
              state_q <= IDLE;
            end else begin
              r_q   <= r_d;
              sat_q <= sat_d;
            end
          end
          default: state_q <= IDLE;
        endcase
      end

      // Result handshake. Data holds after acceptance. Only valid drops.
      if (load) begin
        meas_valid_q <= 1'b1;
        high_cnt_q   <= high_lat_q;
        period_cnt_q <= r_q;
        meas_sat_q   <= sat_q;
      end else if (complete) begin
        overrun_q    <= 1'b1;
      end else if (meas_valid_q && meas_ready) begin
        meas_valid_q <= 1'b0;
      end
    end
  end

  assign meas_valid = meas_valid_q;
  assign high_cnt   = high_cnt_q;
  assign period_cnt = period_cnt_q;
  assign meas_sat   = meas_sat_q;
  assign overrun    = overrun_q;
  assign err        = err_q;

endmodule
